// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared opcodes, register address and FIFO entry types for the issue controller
package issue_pkg;

    localparam int ENTRY_XLEN = 32;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef logic [4:0] regaddr_t;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] instr;
        logic [ENTRY_XLEN-1:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - fetch, decoder, issue and writeback signals of the issue controller
interface issue_ctrl_if
    import issue_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_instr;
    logic [XLEN-1:0] fetch_pc;

    logic [XLEN-1:0] dec_instr;
    logic [6:0]      dec_op;
    regaddr_t        dec_rs1;
    regaddr_t        dec_rs2;
    regaddr_t        dec_rd;

    logic            iss_valid;
    logic            iss_ready;
    logic [XLEN-1:0] iss_instr;
    logic [XLEN-1:0] iss_pc;

    logic            wb_valid;
    regaddr_t        wb_rd;

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc,
        input  dec_op, dec_rs1, dec_rs2, dec_rd,
        input  iss_ready, wb_valid, wb_rd,
        output fetch_ready, dec_instr, iss_valid, iss_instr, iss_pc
    );

    modport master (
        output fetch_valid, fetch_instr, fetch_pc,
        output dec_op, dec_rs1, dec_rs2, dec_rd,
        output iss_ready, wb_valid, wb_rd,
        input  fetch_ready, dec_instr, iss_valid, iss_instr, iss_pc
    );

endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - 32-entry register busy scoreboard and hazard detect; ISSUE_BYPASS_EN masks the writeback register
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  regaddr_t    set_rd,
    input  logic        clr_en,
    input  regaddr_t    clr_rd,
    input  logic [6:0]  op,
    input  regaddr_t    rs1,
    input  regaddr_t    rs2,
    input  regaddr_t    rd,
    output logic [31:0] busy,
    output logic        hazard
);
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] check;
    logic        drain;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_rd != 5'd0) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
    end

`ifdef ISSUE_BYPASS_EN
    assign check = busy & ~clr_mask;
`else
    assign check = busy;
`endif

    assign drain  = ((op == OP_SYSTEM) || (op == OP_FENCE)) && (|check);
    assign hazard = check[rs1] | check[rs2] | check[rd] | drain;

    // set is applied after clear so a same-cycle issue keeps the register pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue controller: fetch FIFO, scoreboard hazard hold, flush; option ISSUE_BYPASS_EN
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = ENTRY_XLEN
)(
    input  logic         clk,
    input  logic         reset,
    issue_ctrl_if.slave  bus,
    input  logic         flush,
    output logic [31:0]  sb_busy,
    output logic [15:0]  stall_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    fifo_entry_t    mem [DEPTH];
    logic [PW-1:0]  rptr;
    logic [PW-1:0]  wptr;
    logic [CW-1:0]  count;
    fifo_entry_t    head;

    logic not_empty;
    logic hazard;
    logic enq;
    logic fire;

    assign head            = mem[rptr];
    assign not_empty       = (count != '0);
    assign bus.fetch_ready = (count < CW'(DEPTH));
    assign enq             = bus.fetch_valid & bus.fetch_ready & ~flush;
    assign bus.iss_valid   = not_empty & ~hazard & ~flush;
    assign fire            = bus.iss_valid & bus.iss_ready;

    assign bus.dec_instr = head.instr;
    assign bus.iss_instr = head.instr;
    assign bus.iss_pc    = head.pc;

    issue_scoreboard u_sb (
        .clk    (clk),
        .reset  (reset),
        .set_en (fire),
        .set_rd (bus.dec_rd),
        .clr_en (bus.wb_valid),
        .clr_rd (bus.wb_rd),
        .op     (bus.dec_op),
        .rs1    (bus.dec_rs1),
        .rs2    (bus.dec_rs2),
        .rd     (bus.dec_rd),
        .busy   (sb_busy),
        .hazard (hazard)
    );

    // storage needs no reset; count qualifies every read
    always_ff @(posedge clk) begin
        if (enq) mem[wptr] <= '{instr: bus.fetch_instr, pc: bus.fetch_pc};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq)  wptr <= wptr + PW'(1);
            if (fire) rptr <= rptr + PW'(1);
            case ({enq, fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (not_empty && hazard && !flush && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;
    import issue_pkg::*;

    localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
    localparam logic [31:0] ADDI_X2 = 32'h0020_0113;
    localparam logic [31:0] ADD_X3  = 32'h0010_81B3;
    localparam logic [31:0] ADDI_X5 = 32'h0050_0293;
    localparam logic [31:0] ADDI_X6 = 32'h0060_0313;
    localparam logic [31:0] ADDI_X7 = 32'h0070_0393;
    localparam logic [31:0] LW_X5   = 32'h0000_0283;
    localparam logic [31:0] FENCE   = 32'h0FF0_000F;
`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] sb_busy;
    logic [15:0] stall_cnt;
    int          checks = 0;
    int          errors = 0;

    issue_ctrl_if #(.XLEN(32)) bus ();

    issue_ctrl #(.DEPTH(2), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .flush     (flush),
        .sb_busy   (sb_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // reference decoder: R-type uses rs1/rs2/rd, OP-IMM and LOAD use rs1/rd, others none
    always_comb begin
        bus.dec_op  = bus.dec_instr[6:0];
        bus.dec_rs1 = '0;
        bus.dec_rs2 = '0;
        bus.dec_rd  = '0;
        case (bus.dec_instr[6:0])
            7'b0110011: begin
                bus.dec_rs1 = bus.dec_instr[19:15];
                bus.dec_rs2 = bus.dec_instr[24:20];
                bus.dec_rd  = bus.dec_instr[11:7];
            end
            7'b0010011, 7'b0000011: begin
                bus.dec_rs1 = bus.dec_instr[19:15];
                bus.dec_rd  = bus.dec_instr[11:7];
            end
            default: ;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = instr;
        bus.fetch_pc    = pc;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0;
        bus.fetch_valid = 1'b0; bus.fetch_instr = '0; bus.fetch_pc = '0;
        bus.iss_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
        tick; tick;
        reset = 1'b0;
        #1;
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready got %0b want 1", bus.fetch_ready); end
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %0b want 0", bus.iss_valid); end
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL reset_sb_busy got %h want 0", sb_busy); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_independent;
        bus.iss_ready = 1'b1;
        offer(ADDI_X1, 32'h100);
        tick;
        offer(ADDI_X2, 32'h104);
        #1;
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_instr !== ADDI_X1 || bus.iss_pc !== 32'h100) begin
            errors++; $display("FAIL indep_first got v=%0b i=%h pc=%h want v=1 i=%h pc=100", bus.iss_valid, bus.iss_instr, bus.iss_pc, ADDI_X1); end
        tick;
        bus.fetch_valid = 1'b0;
        #1;
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_instr !== ADDI_X2 || bus.iss_pc !== 32'h104) begin
            errors++; $display("FAIL indep_second got v=%0b i=%h pc=%h want v=1 i=%h pc=104", bus.iss_valid, bus.iss_instr, bus.iss_pc, ADDI_X2); end
        tick;
        checks++; if (sb_busy !== 32'h6) begin errors++; $display("FAIL indep_sb_busy got %h want 6", sb_busy); end
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL indep_empty got %0b want 0", bus.iss_valid); end
    endtask

    task automatic test_raw_stall;
        offer(ADD_X3, 32'h108);
        tick;
        bus.fetch_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3 && !BYP) begin bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; end
            #1;
            checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL raw_stall_c%0d got %0b want 0", c, bus.iss_valid); end
            tick;
            bus.wb_valid = 1'b0;
        end
        if (BYP) begin bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; end
        #1;
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_instr !== ADD_X3) begin
            errors++; $display("FAIL raw_issue got v=%0b i=%h want v=1 i=%h", bus.iss_valid, bus.iss_instr, ADD_X3); end
        tick;
        bus.wb_valid = 1'b0;
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_stall_cnt got %0d want 3", stall_cnt); end
        checks++; if (sb_busy !== 32'hC) begin errors++; $display("FAIL raw_sb_busy got %h want c", sb_busy); end
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; tick;
        bus.wb_rd = 5'd3; tick;
        bus.wb_valid = 1'b0;
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL raw_drain_busy got %h want 0", sb_busy); end
    endtask

    task automatic test_full_fifo;
        bus.iss_ready = 1'b0;
        offer(ADDI_X5, 32'h200);
        tick;
        offer(ADDI_X6, 32'h204);
        #1;
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL full_second_ready got %0b want 1", bus.fetch_ready); end
        tick;
        offer(ADDI_X7, 32'h208);
        #1;
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %0b want 0", bus.fetch_ready); end
        tick;
        bus.iss_ready = 1'b1;
        #1;
        checks++; if (bus.fetch_ready !== 1'b0 || bus.iss_instr !== ADDI_X5) begin
            errors++; $display("FAIL full_no_passthru got rdy=%0b i=%h want rdy=0 i=%h", bus.fetch_ready, bus.iss_instr, ADDI_X5); end
        tick;
        bus.iss_ready = 1'b0;
        #1;
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_fire got %0b want 1", bus.fetch_ready); end
        tick;
        bus.fetch_valid = 1'b0;
        #1;
        checks++; if (bus.iss_instr !== ADDI_X6 || sb_busy !== 32'h20 || bus.fetch_ready !== 1'b0) begin
            errors++; $display("FAIL full_state got i=%h busy=%h rdy=%0b want i=%h busy=20 rdy=0", bus.iss_instr, sb_busy, bus.fetch_ready, ADDI_X6); end
    endtask

    task automatic test_flush;
        flush = 1'b1;
        #1;
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_gate got %0b want 0", bus.iss_valid); end
        tick;
        flush = 1'b0;
        #1;
        checks++; if (bus.iss_valid !== 1'b0 || bus.fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty got v=%0b rdy=%0b want v=0 rdy=1", bus.iss_valid, bus.fetch_ready); end
        checks++; if (sb_busy !== 32'h20) begin errors++; $display("FAIL flush_sb_kept got %h want 20", sb_busy); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL flush_stall_kept got %0d want 3", stall_cnt); end
    endtask

    task automatic test_collision;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
        tick;
        bus.wb_valid = 1'b0;
        checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL coll_clear got %h want 0", sb_busy); end
        offer(LW_X5, 32'h280);
        tick;
        bus.fetch_valid = 1'b0;
        bus.iss_ready = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
        #1;
        checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL coll_issue got %0b want 1", bus.iss_valid); end
        tick;
        bus.wb_valid = 1'b0;
        checks++; if (sb_busy !== 32'h20) begin errors++; $display("FAIL coll_set_wins got %h want 20", sb_busy); end
    endtask

    task automatic test_fence_drain;
        offer(FENCE, 32'h300);
        tick;
        bus.fetch_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL fence_hold_c%0d got %0b want 0", c, bus.iss_valid); end
            tick;
        end
        bus.iss_ready = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
        #1;
        checks++; if (bus.iss_valid !== BYP) begin errors++; $display("FAIL fence_wb_cycle got %0b want %0b", bus.iss_valid, BYP); end
        tick;
        bus.wb_valid = 1'b0;
        bus.iss_ready = 1'b1;
        #1;
        checks++; if (bus.iss_valid !== 1'b1 || bus.iss_instr !== FENCE || bus.iss_pc !== 32'h300) begin
            errors++; $display("FAIL fence_issue got v=%0b i=%h pc=%h want v=1 i=%h pc=300", bus.iss_valid, bus.iss_instr, bus.iss_pc, FENCE); end
        tick;
        checks++; if (bus.iss_valid !== 1'b0 || sb_busy !== 32'h0) begin
            errors++; $display("FAIL fence_after got v=%0b busy=%h want v=0 busy=0", bus.iss_valid, sb_busy); end
        checks++; if (stall_cnt !== (BYP ? 16'd5 : 16'd6)) begin
            errors++; $display("FAIL fence_stall_cnt got %0d want %0d", stall_cnt, BYP ? 5 : 6); end
    endtask

    task automatic test_async_reset;
        bus.iss_ready = 1'b1;
        offer(ADDI_X1, 32'h400);
        tick;
        bus.fetch_valid = 1'b0;
        tick;
        bus.iss_ready = 1'b0;
        offer(ADDI_X2, 32'h404);
        tick;
        bus.fetch_valid = 1'b0;
        #1;
        checks++; if (bus.iss_valid !== 1'b1 || sb_busy !== 32'h2) begin
            errors++; $display("FAIL areset_pre got v=%0b busy=%h want v=1 busy=2", bus.iss_valid, sb_busy); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.iss_valid !== 1'b0 || sb_busy !== 32'h0 || stall_cnt !== 16'h0) begin
            errors++; $display("FAIL areset_async got v=%0b busy=%h stall=%0d want all 0", bus.iss_valid, sb_busy, stall_cnt); end
        tick;
        reset = 1'b0;
        #1;
        checks++; if (bus.fetch_ready !== 1'b1 || bus.iss_valid !== 1'b0) begin
            errors++; $display("FAIL areset_release got rdy=%0b v=%0b want rdy=1 v=0", bus.fetch_ready, bus.iss_valid); end
    endtask

    initial begin
        test_reset;
        test_independent;
        test_raw_stall;
        test_full_fifo;
        test_flush;
        test_collision;
        test_fence_drain;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
